// File: rtl/i2c_slave_read_responder_if.sv
// Bus-side bundle for the I2C read responder: oversampled SCL/SDA, open-drain enable, fabric data.
// Latency: n/a (wires only).
// Backpressure: none; the I2C target cannot stretch SCL, so the master sets the pace.
//
// Signals:
//   SCL_IN, SDA_IN   bus line levels seen by the target
//   SDA_OE           1 = target pulls SDA low
//   SLAVE_ADDRESS    8-bit address form, [7:1] matched
//   TX_DATA          16-bit word served on reads, MSB byte first
//   RX_DATA/RX_VALID last byte written by the master, one-cycle strobe
//   READ_DONE        one-cycle strobe when the master NACKs a read byte
//   BUSY, ST         transaction flag and state code
interface i2c_slave_read_responder_if;
  logic        SCL_IN;
  logic        SDA_IN;
  logic        SDA_OE;
  logic [7:0]  SLAVE_ADDRESS;
  logic [15:0] TX_DATA;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        READ_DONE;
  logic        BUSY;
  logic [3:0]  ST;

  modport slave (
    input  SCL_IN, SDA_IN, SLAVE_ADDRESS, TX_DATA,
    output SDA_OE, RX_DATA, RX_VALID, READ_DONE, BUSY, ST
  );

  modport master (
    output SCL_IN, SDA_IN, SLAVE_ADDRESS, TX_DATA,
    input  SDA_OE, RX_DATA, RX_VALID, READ_DONE, BUSY, ST
  );
endinterface

// File: rtl/i2c_slave_read_responder.sv
// I2C target: answers reads with a latched 16-bit word (MSB byte first, 0xFF filler) and accepts byte writes.
// Latency: SDA_OE updates SYNC_STAGES+1 CLK edges after SCL falls on the bus.
// Backpressure: none; no clock stretching, every byte is ACKed/served at the master's pace.
//
// Ports:
//   CLK      system clock, at least 8x SCL
//   RESET_N  asynchronous active-low reset; releases SDA immediately
//   i2c      slave modport of i2c_slave_read_responder_if (bus lines, data, status)
module i2c_slave_read_responder #(
  parameter int NBYTES      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             CLK,
  input  logic                             RESET_N,
  i2c_slave_read_responder_if.slave        i2c
);

  localparam int IW = (NBYTES < 1) ? 1 : $clog2(NBYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_TX_BYTE   = 3'd3,
    S_TX_ACK    = 3'd4,
    S_RX_BYTE   = 3'd5,
    S_RX_ACK    = 3'd6,
    S_WAIT_STOP = 3'd7
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;

  state_t                 r_state;
  logic [3:0]             r_bit_cnt;
  logic [IW-1:0]          r_byte_idx;
  logic [7:0]             r_shift;
  logic                   r_rw;
  logic                   r_ack_drv;
  logic [15:0]            r_tx_word;
  logic                   r_sda_oe;
  logic [7:0]             r_rx_data;
  logic                   r_rx_valid;
  logic                   r_read_done;
  logic                   r_busy;

  logic                   w_scl;
  logic                   w_sda;
  logic                   w_scl_rise;
  logic                   w_scl_fall;
  logic                   w_start;
  logic                   w_stop;
  logic [7:0]             w_rx_byte;
  logic                   w_in_word;
  logic [7:0]             w_cur_byte;
  logic                   w_unused;

  // Bus lines idle high, so the synchronizers reset to 1 to avoid a false edge out of reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i2c.SCL_IN};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i2c.SDA_IN};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  // START/STOP need SCL high on both sides of the SDA edge.
  assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
  assign w_rx_byte  = {r_shift[6:0], w_sda};

  // Only two bytes exist in the word; anything past them or past NBYTES is filler.
  assign w_in_word  = (32'(r_byte_idx) < NBYTES) && (32'(r_byte_idx) < 2);
  assign w_cur_byte = !w_in_word     ? 8'hFF :
                      r_byte_idx[0]  ? r_tx_word[7:0] : r_tx_word[15:8];

  // The R/W position of the configured address is don't-care.
  assign w_unused   = i2c.SLAVE_ADDRESS[0];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_byte_idx  <= '0;
      r_shift     <= '0;
      r_rw        <= 1'b0;
      r_ack_drv   <= 1'b0;
      r_tx_word   <= '0;
      r_sda_oe    <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_read_done <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_read_done <= 1'b0;
      if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= '0;
        r_ack_drv <= 1'b0;
        r_sda_oe  <= 1'b0;
      end else if (w_stop) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= '0;
        r_ack_drv <= 1'b0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_sda_oe <= 1'b0;
          end
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift <= w_rx_byte;
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt <= '0;
                if (w_rx_byte[7:1] == i2c.SLAVE_ADDRESS[7:1]) begin
                  r_rw    <= w_rx_byte[0];
                  r_busy  <= 1'b1;
                  r_state <= S_ADDR_ACK;
                end else begin
                  r_state <= S_WAIT_STOP;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_drv) begin
                r_sda_oe  <= 1'b1;
                r_ack_drv <= 1'b1;
              end else begin
                r_ack_drv <= 1'b0;
                if (r_rw) begin
                  // The fall that ends the ACK also presents the first data bit.
                  r_tx_word  <= i2c.TX_DATA;
                  r_byte_idx <= '0;
                  r_sda_oe   <= (NBYTES > 0) ? ~i2c.TX_DATA[15] : 1'b0;
                  r_bit_cnt  <= 4'd1;
                  r_state    <= S_TX_BYTE;
                end else begin
                  r_sda_oe  <= 1'b0;
                  r_bit_cnt <= '0;
                  r_state   <= S_RX_BYTE;
                end
              end
            end
          end
          S_TX_BYTE: begin
            // r_bit_cnt counts bits already placed on the bus.
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= '0;
                r_state   <= S_TX_ACK;
              end else begin
                r_sda_oe  <= ~w_cur_byte[~r_bit_cnt[2:0]];
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          S_TX_ACK: begin
            if (w_scl_rise) begin
              if (!w_sda) begin
                if (32'(r_byte_idx) < NBYTES) begin
                  r_byte_idx <= r_byte_idx + 1'b1;
                end
                r_state <= S_TX_BYTE;
              end else begin
                r_read_done <= 1'b1;
                r_state     <= S_WAIT_STOP;
              end
            end
          end
          S_RX_BYTE: begin
            if (w_scl_rise) begin
              r_shift <= w_rx_byte;
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt  <= '0;
                r_rx_data  <= w_rx_byte;
                r_rx_valid <= 1'b1;
                r_state    <= S_RX_ACK;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          S_RX_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_drv) begin
                r_sda_oe  <= 1'b1;
                r_ack_drv <= 1'b1;
              end else begin
                r_sda_oe  <= 1'b0;
                r_ack_drv <= 1'b0;
                r_state   <= S_RX_BYTE;
              end
            end
          end
          S_WAIT_STOP: begin
            r_sda_oe <= 1'b0;
          end
          default: begin
            r_sda_oe <= 1'b0;
            r_state  <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign i2c.SDA_OE    = r_sda_oe;
  assign i2c.RX_DATA   = r_rx_data;
  assign i2c.RX_VALID  = r_rx_valid;
  assign i2c.READ_DONE = r_read_done;
  assign i2c.BUSY      = r_busy;
  assign i2c.ST        = {1'b0, r_state};

endmodule

// File: tb/tb_i2c_slave_read_responder.sv
module tb_i2c_slave_read_responder;

  localparam int Q  = 5;   // CLK cycles per quarter SCL period
  localparam int NB = 2;
  localparam int SS = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl   = 1'b1;
  logic        sda_m = 1'b1;
  logic [7:0]  slave_addr = 8'h90;
  logic [15:0] tx_data    = 16'h0000;

  int vectors     = 0;
  int miscompares = 0;
  int rxv_cnt     = 0;
  int rd_cnt      = 0;
  int oe_cnt      = 0;
  int busy_cnt    = 0;
  int oe_viol     = 0;
  logic prev_oe   = 1'b0;

  i2c_slave_read_responder_if bus();

  assign bus.SCL_IN        = scl;
  assign bus.SDA_IN        = sda_m & ~bus.SDA_OE;
  assign bus.SLAVE_ADDRESS = slave_addr;
  assign bus.TX_DATA       = tx_data;

  i2c_slave_read_responder #(.NBYTES(NB), .SYNC_STAGES(SS)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .i2c     (bus)
  );

  always #5 clk = ~clk;

  // Pulse counters and a watch on SDA_OE changing while SCL is high.
  always @(posedge clk) begin
    if (bus.RX_VALID)  rxv_cnt++;
    if (bus.READ_DONE) rd_cnt++;
    if (bus.SDA_OE)    oe_cnt++;
    if (bus.BUSY)      busy_cnt++;
    if (rst_n && scl && (bus.SDA_OE !== prev_oe)) oe_viol++;
    prev_oe = bus.SDA_OE;
  end

  // Reference model
  function automatic logic model_match(input logic [7:0] sa, input logic [7:0] a);
    return (sa >> 1) == (a >> 1);
  endfunction

  function automatic logic [7:0] model_byte(input logic [15:0] word, input int k);
    if (k < NB && k < 2) return 8'((word >> (8 * (1 - k))) & 16'h00FF);
    return 8'hFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl   = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl   = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl   = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic bit_out(input logic b);
    sda_m = b; wq();
    scl = 1'b1; wq(); wq();
    scl = 1'b0; wq();
  endtask

  task automatic bit_in(output logic b, output logic drv);
    sda_m = 1'b1; wq();
    scl = 1'b1; wq();
    b   = bus.SDA_IN;
    drv = bus.SDA_OE;
    wq();
    scl = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b, drv;
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(b, drv);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, output logic any_drv, input logic ack);
    logic b, drv;
    any_drv = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b, drv);
      d[i] = b;
      any_drv |= drv;
    end
    bit_out(ack ? 1'b0 : 1'b1);
  endtask

  task automatic do_read(input logic [7:0] a, input int n, input string tag);
    logic ack, drv, exp_ack;
    logic [7:0] d;
    logic [15:0] tx_lat;
    int rd0;
    exp_ack = model_match(slave_addr, a);
    rd0 = rd_cnt;
    i2c_start();
    write_byte({a[7:1], 1'b1}, ack);
    check({tag, "_addr_ack"}, 32'(ack), 32'(exp_ack));
    if (exp_ack) begin
      tx_lat  = tx_data;
      tx_data = 16'($urandom);   // must not affect this transaction
      for (int k = 0; k < n; k++) begin
        read_byte(d, drv, k != n - 1);
        check({tag, "_byte"}, 32'(d), 32'(model_byte(tx_lat, k)));
        if (k >= NB) check({tag, "_filler_drv"}, 32'(drv), 32'd0);
      end
      check({tag, "_busy_hi"}, 32'(bus.BUSY), 32'd1);
    end
    i2c_stop(); wq();
    check({tag, "_read_done"}, 32'(rd_cnt - rd0), exp_ack ? 32'd1 : 32'd0);
    check({tag, "_busy_lo"}, 32'(bus.BUSY), 32'd0);
    check({tag, "_st_idle"}, 32'(bus.ST), 32'd0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] b0, input int n, input string tag);
    logic ack, exp_ack;
    logic [7:0] d;
    int rxv0;
    exp_ack = model_match(slave_addr, a);
    rxv0 = rxv_cnt;
    i2c_start();
    write_byte({a[7:1], 1'b0}, ack);
    check({tag, "_addr_ack"}, 32'(ack), 32'(exp_ack));
    for (int k = 0; k < n; k++) begin
      d = (k == 0) ? b0 : 8'($urandom);
      write_byte(d, ack);
      check({tag, "_data_ack"}, 32'(ack), 32'(exp_ack));
      if (exp_ack) check({tag, "_rx_data"}, 32'(bus.RX_DATA), 32'(d));
    end
    i2c_stop(); wq();
    check({tag, "_rx_valid"}, 32'(rxv_cnt - rxv0), exp_ack ? 32'(n) : 32'd0);
    check({tag, "_busy_lo"}, 32'(bus.BUSY), 32'd0);
  endtask

  initial begin
    logic ack, b, drv;
    logic [7:0] d, a;
    logic [15:0] tx_lat;
    int rd0, rxv0, oe0, busy0;

    // Reset values
    repeat (4) @(negedge clk);
    check("rst_sda_oe",    32'(bus.SDA_OE),    32'd0);
    check("rst_rx_data",   32'(bus.RX_DATA),   32'd0);
    check("rst_rx_valid",  32'(bus.RX_VALID),  32'd0);
    check("rst_read_done", 32'(bus.READ_DONE), 32'd0);
    check("rst_busy",      32'(bus.BUSY),      32'd0);
    check("rst_st",        32'(bus.ST),        32'd0);
    rst_n = 1'b1;
    wq();

    // Two-byte read of 0xA55A, then a three-byte read with filler
    slave_addr = 8'h90; tx_data = 16'hA55A;
    do_read(8'h90, 2, "read2");
    tx_data = 16'hA55A;
    do_read(8'h90, 3, "read3");

    // Single-byte write of 0x3C
    do_write(8'h90, 8'h3C, 1, "write3c");

    // Non-matching address: SDA never driven, BUSY never set
    oe0 = oe_cnt; busy0 = busy_cnt;
    do_read(8'h92, 2, "nomatch");
    check("nomatch_oe_never",   32'(oe_cnt - oe0),     32'd0);
    check("nomatch_busy_never", 32'(busy_cnt - busy0), 32'd0);

    // General call
    do_write(8'h00, 8'h55, 1, "gcall_nack");
    slave_addr = 8'h01;
    do_write(8'h00, 8'hC3, 1, "gcall_ack");
    slave_addr = 8'h90;

    // STOP after 4 bits of the first read byte; bit 11 is a 1 so the line is free for STOP
    tx_data = 16'($urandom) | 16'h0800;
    tx_lat  = tx_data;
    rd0 = rd_cnt;
    i2c_start();
    write_byte(8'h91, ack);
    check("midstop_addr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bit_in(b, drv);
      d[7 - i] = b;
    end
    check("midstop_nibble", 32'(d[7:4]), 32'(tx_lat[15:12]));
    sda_m = 1'b0; wq();
    scl   = 1'b1; wq();
    sda_m = 1'b1;
    repeat (SS + 2) @(negedge clk);
    check("midstop_oe",   32'(bus.SDA_OE), 32'd0);
    check("midstop_st",   32'(bus.ST),     32'd0);
    check("midstop_busy", 32'(bus.BUSY),   32'd0);
    wq();
    check("midstop_no_read_done", 32'(rd_cnt - rd0), 32'd0);

    // STOP in the middle of a written byte discards it
    rxv0 = rxv_cnt;
    i2c_start();
    write_byte(8'h90, ack);
    check("midwr_addr_ack", 32'(ack), 32'd1);
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1);
    i2c_stop(); wq();
    check("midwr_no_rx_valid", 32'(rxv_cnt - rxv0), 32'd0);
    check("midwr_rx_data",     32'(bus.RX_DATA),    32'hC3);

    // Write 0x01, repeated START, then read the word present at the second address ACK
    rxv0 = rxv_cnt; rd0 = rd_cnt;
    tx_data = 16'($urandom);
    i2c_start();
    write_byte(8'h90, ack);
    check("rs_addr_w_ack", 32'(ack), 32'd1);
    write_byte(8'h01, ack);
    check("rs_data_ack", 32'(ack), 32'd1);
    check("rs_rx_data",  32'(bus.RX_DATA), 32'h01);
    tx_data = 16'($urandom);
    tx_lat  = tx_data;
    i2c_start();
    check("rs_st_addr", 32'(bus.ST), 32'd1);
    write_byte(8'h91, ack);
    check("rs_addr_r_ack", 32'(ack), 32'd1);
    tx_data = ~tx_lat;
    for (int k = 0; k < 2; k++) begin
      read_byte(d, drv, k == 0);
      check("rs_byte", 32'(d), 32'(model_byte(tx_lat, k)));
    end
    i2c_stop(); wq();
    check("rs_rx_valid",  32'(rxv_cnt - rxv0), 32'd1);
    check("rs_read_done", 32'(rd_cnt - rd0),   32'd1);

    // Randomized transactions
    for (int it = 0; it < 12; it++) begin
      slave_addr = 8'($urandom);
      tx_data    = 16'($urandom);
      a = ($urandom_range(0, 3) != 0) ? {slave_addr[7:1], 1'($urandom)} : 8'($urandom);
      if ($urandom_range(0, 1) == 1)
        do_read(a, $urandom_range(1, 4), "rnd_read");
      else
        do_write(a, 8'($urandom), $urandom_range(1, 3), "rnd_write");
    end

    // Reset while the target is driving a data bit low
    slave_addr = 8'h90; tx_data = 16'h0000;
    i2c_start();
    write_byte(8'h91, ack);
    check("rstmid_addr_ack", 32'(ack), 32'd1);
    check("rstmid_oe_before", 32'(bus.SDA_OE), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_oe_after", 32'(bus.SDA_OE), 32'd0);
    scl = 1'b1; sda_m = 1'b1;
    wq();
    check("rstmid_st", 32'(bus.ST), 32'd0);
    rst_n = 1'b1;
    wq();

    check("oe_change_while_scl_high", 32'(oe_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not complete, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_slave_read_responder.md
Name: i2c_slave_read_responder

Overview:
- I2C target (slave) that answers the sensor-side 2-byte read transaction issued by our bit-banged I2C master, and accepts single-byte writes.
- Oversamples the SCL/SDA lines on a fast system clock and drives SDA open-drain.
- Serves a 16-bit parallel word, MSB byte first, in the same byte order the master assembles its 16-bit result.
- Sits in the sensor emulation and loopback test path, bridging bus-side I2C to fabric registers.

Parameters:
- NBYTES, 2, number of bytes served per read transaction before the block returns 0xFF filler.
- SYNC_STAGES, 2, synchronizer flops on SCL_IN and SDA_IN (minimum 2).

Ports:
- CLK  in  1  system clock; must be at least 8x the SCL frequency.
- RESET_N  in  1  reset, asynchronous, active-low.
- SCL_IN  in  1  bus SCL level (input only; no clock stretching).
- SDA_IN  in  1  bus SDA level.
- SDA_OE  out  1  1 = pull SDA low; 0 = release the line.
- SLAVE_ADDRESS  in  8  8-bit address form; bits [7:1] are matched and bit 0 is ignored.
- TX_DATA  in  16  word served on reads; latched at address ACK.
- RX_DATA  out  8  last byte written by the master.
- RX_VALID  out  1  one-CLK pulse when RX_DATA updates.
- READ_DONE  out  1  one-CLK pulse when the master NACKs the final read byte.
- BUSY  out  1  high from an addressed START until STOP.
- ST  out  4  state code, for test.

Behaviour:
- Reset values: SDA_OE=0, RX_DATA=0, RX_VALID=0, READ_DONE=0, BUSY=0, ST=IDLE, bit/byte counters=0. Reset asserted mid-transfer releases SDA in the same cycle.
- Synchronizers:
  - SCL_IN and SDA_IN each pass through SYNC_STAGES flops.
  - Edges are detected against the previous synchronized value.
  - SCL_RISE/SCL_FALL, START (SDA falls while SCL high), STOP (SDA rises while SCL high) are single-cycle events.
- Global rules, which take priority over the state table:
  - START in any state: go to ADDR, clear the bit counter, release SDA.
  - A START inside a transaction is treated as a repeated start.
  - STOP in any state: go to IDLE, SDA_OE=0, BUSY=0.
- Data sampling and driving:
  - Data is sampled on SCL_RISE, MSB first.
  - SDA_OE changes only on the CLK cycle after SCL_FALL, never while SCL is high.
- States:
  - IDLE (0): wait for START.
  - ADDR (1): shift 8 bits on SCL_RISE. After bit 8:
    - If addr[7:1] matches SLAVE_ADDRESS[7:1], go to ADDR_ACK and set BUSY=1.
    - Otherwise go to WAIT_STOP without driving.
  - ADDR_ACK (2):
    - On SCL_FALL, drive SDA_OE=1.
    - On the following SCL_FALL, release SDA.
    - Go to TX_BYTE if R/W=1; in that case, latch TX_DATA into the shift buffer and set byte index=0.
    - Go to RX_BYTE if R/W=0.
  - TX_BYTE (3):
    - After each SCL_FALL, SDA_OE = ~current bit.
    - Byte index k<NBYTES serves TX_DATA[15-8k -: 8]; k>=NBYTES serves 0xFF.
    - After the 8th bit's SCL_FALL, release SDA and go to TX_ACK.
  - TX_ACK (4): sample SDA on SCL_RISE.
    - 0 (ACK): increment the byte index (saturating at NBYTES) and return to TX_BYTE.
    - 1 (NACK): pulse READ_DONE and go to WAIT_STOP.
  - RX_BYTE (5): shift 8 bits on SCL_RISE. On the 8th bit, update RX_DATA, pulse RX_VALID, and go to RX_ACK.
  - RX_ACK (6): drive ACK on SCL_FALL, release it on the next SCL_FALL, then return to RX_BYTE.
  - WAIT_STOP (7): SDA released; wait for STOP or START.
- Latency: SDA_OE follows SCL_FALL by SYNC_STAGES+1 CLK cycles.
- Boundary cases:
  - STOP or START in the middle of a byte discards the partial byte and produces no RX_VALID.
  - TX_DATA changes after address ACK have no effect on the current transaction.
  - General-call address 0x00 is not acknowledged unless SLAVE_ADDRESS[7:1]=0.

Test Plan:
- SLAVE_ADDRESS=0x90, TX_DATA=0xA55A; master reads 2 bytes (ACK, then NACK) -> address ACK low; bus bytes 0xA5, 0x5A; one READ_DONE pulse; BUSY falls at STOP.
- Same setup, master ACKs a 3rd byte -> third byte is 0xFF; SDA is never driven during it.
- Master writes address 0x90, then 0x3C -> two ACKs; RX_DATA=0x3C with a single RX_VALID pulse.
- Master addresses 0x92 -> SDA_OE stays 0 for the entire transaction; BUSY stays 0.
- STOP injected after 4 bits of the first data byte during a read -> SDA_OE=0 within SYNC_STAGES+2 cycles; ST=IDLE; no READ_DONE.
- Repeated START after a write of 0x01, followed by a read -> ADDR is re-entered; returns TX_DATA latched at the second address ACK.
